// File: rtl/glyph_pkg.sv
// Glyph codes, geometry and the 5x5 master font shared by the ROM and the renderer.
// Each master-font cell is stretched to fill the full GLYPH_W x GLYPH_H bitmap.
package glyph_pkg;

   localparam int GLYPH_W    = 20;
   localparam int GLYPH_H    = 20;
   localparam int NUM_GLYPHS = 8;
   localparam int FONT_N     = 5;

   localparam int CHAR_N     = 0;
   localparam int CHAR_E     = 1;
   localparam int CHAR_W     = 2;
   localparam int BLANK_CODE = 3;
   localparam int CHAR_G     = 4;
   localparam int CHAR_A     = 5;
   localparam int CHAR_M     = 6;
   localparam int CHAR_E2    = 7;

   // Row-major, MSB = top-left cell, five bits per row.
   localparam logic [24:0] FONT [8] = '{
      25'b10001_11001_10101_10011_10001,  // N
      25'b11111_10000_11110_10000_11111,  // E
      25'b10001_10001_10101_11011_10001,  // W
      25'b00000_00000_00000_00000_00000,  // blank
      25'b01111_10000_10011_10001_01111,  // G
      25'b01110_10001_11111_10001_10001,  // A
      25'b10001_11011_10101_10001_10001,  // M
      25'b11111_10000_11110_10000_11111   // E
   };

   function automatic logic font_pixel(input int code, input int frow, input int fcol);
      if (code < 0 || code >= NUM_GLYPHS || frow < 0 || frow >= FONT_N ||
          fcol < 0 || fcol >= FONT_N)
         return 1'b0;
      return FONT[3'(code)][5'(24 - (frow * FONT_N + fcol))];
   endfunction

endpackage

// File: rtl/glyph_rom.sv
// Glyph bitmap ROM addressed by {code, row}; registered read with one cycle of latency.
// Rows at or beyond GLYPH_H and codes at or beyond NUM_GLYPHS read as all zeros.
module glyph_rom #(
   parameter int GLYPH_W    = 20,
   parameter int GLYPH_H    = 20,
   parameter int NUM_GLYPHS = 8,
   parameter int CODE_W     = 3,
   parameter int ROW_W      = 5
) (
   input  logic                     clock_25,
   input  logic [CODE_W+ROW_W-1:0]  addr,
   output logic [GLYPH_W-1:0]       row_bits
);
   import glyph_pkg::*;

   logic [CODE_W-1:0]  code;
   logic [ROW_W-1:0]   row;
   logic [GLYPH_W-1:0] rom_d;

   assign {code, row} = addr;

   always_comb begin
      rom_d = '0;
      if (int'(row) < GLYPH_H && int'(code) < NUM_GLYPHS) begin
         for (int c = 0; c < GLYPH_W; c++)
            rom_d[GLYPH_W-1-c] = font_pixel(int'(code), int'(row) * FONT_N / GLYPH_H,
                                            c * FONT_N / GLYPH_W);
      end
   end

   always_ff @(posedge clock_25)
      row_bits <= rom_d;

endmodule

// File: rtl/glyph_text_renderer.sv
// Text overlay: shadow/active glyph strings, region mapping and a fixed 3-stage pixel pipeline.
// Optional blinking is built in when the macro GLYPH_BLINK_EN is defined.
module glyph_text_renderer #(
   parameter int GLYPH_W      = glyph_pkg::GLYPH_W,
   parameter int GLYPH_H      = glyph_pkg::GLYPH_H,
   parameter int NUM_GLYPHS   = glyph_pkg::NUM_GLYPHS,
   parameter int STR_LEN      = 8,
   parameter int X0           = 240,
   parameter int Y0           = 230,
   parameter int SCALE_LOG2   = 0,
   parameter int BLINK_FRAMES = 30,
   localparam int CODE_W      = $clog2(NUM_GLYPHS),
   localparam int SLOT_W      = $clog2(STR_LEN)
) (
   input  logic              clock_25,
   input  logic              resetn,
   input  logic              frame_start,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   input  logic              pixel_valid,
   input  logic              text_enable,
   input  logic              wr_en,
   input  logic [SLOT_W-1:0] wr_slot,
   input  logic [CODE_W-1:0] wr_code,
   output logic              pixel_on,
   output logic              pixel_on_valid
);
   import glyph_pkg::*;

   localparam int COL_W = $clog2(GLYPH_W);
   localparam int ROW_W = $clog2(GLYPH_H);
   localparam int X_END = X0 + STR_LEN * GLYPH_W * (1 << SCALE_LOG2);
   localparam int Y_END = Y0 + GLYPH_H * (1 << SCALE_LOG2);

   if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2 || BLINK_FRAMES < 1 || BLINK_FRAMES > 256) begin : g_bad_cfg
      $error("glyph_text_renderer: SCALE_LOG2 or BLINK_FRAMES out of range");
   end

   logic [CODE_W-1:0] shadow [STR_LEN];
   logic [CODE_W-1:0] active [STR_LEN];

   // Commit copies the pre-write shadow, so a coincident write waits for the next frame.
   always_ff @(posedge clock_25) begin
      if (!resetn) begin
         for (int i = 0; i < STR_LEN; i++) begin
            shadow[i] <= CODE_W'(BLANK_CODE);
            active[i] <= CODE_W'(BLANK_CODE);
         end
      end else begin
         if (wr_en && 32'(wr_slot) < STR_LEN)
            shadow[wr_slot] <= wr_code;
         if (frame_start)
            active <= shadow;
      end
   end

   logic text_visible;
`ifdef GLYPH_BLINK_EN
   logic [7:0] blink_cnt;

   always_ff @(posedge clock_25) begin
      if (!resetn) begin
         blink_cnt    <= 8'd0;
         text_visible <= 1'b1;
      end else if (frame_start) begin
         if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
            blink_cnt    <= 8'd0;
            text_visible <= ~text_visible;
         end else begin
            blink_cnt <= blink_cnt + 8'd1;
         end
      end
   end
`else
   assign text_visible = 1'b1;
`endif

   logic              in_region;
   logic [9:0]        dx, dy, sx;
   logic [SLOT_W-1:0] slot;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;

   assign in_region = pixel_valid &&
                      int'(pixel_x) >= X0 && int'(pixel_x) < X_END &&
                      int'(pixel_y) >= Y0 && int'(pixel_y) < Y_END;
   assign dx   = pixel_x - 10'(X0);
   assign dy   = pixel_y - 10'(Y0);
   assign sx   = dx >> SCALE_LOG2;
   assign slot = SLOT_W'(sx / 10'(GLYPH_W));
   assign col  = COL_W'(sx % 10'(GLYPH_W));
   assign row  = ROW_W'(dy >> SCALE_LOG2);

   logic                    s1_valid, s1_hit, s2_valid, s2_hit;
   logic [COL_W-1:0]        s1_col, s2_col;
   logic [CODE_W+ROW_W-1:0] s1_addr;
   logic [GLYPH_W-1:0]      rom_row;

   always_ff @(posedge clock_25) begin
      if (!resetn) begin
         s1_valid       <= 1'b0;
         s1_hit         <= 1'b0;
         s1_col         <= '0;
         s1_addr        <= '0;
         s2_valid       <= 1'b0;
         s2_hit         <= 1'b0;
         s2_col         <= '0;
         pixel_on       <= 1'b0;
         pixel_on_valid <= 1'b0;
      end else begin
         s1_valid       <= pixel_valid;
         s1_hit         <= in_region && text_enable && text_visible;
         s1_col         <= col;
         s1_addr        <= {active[slot], row};
         s2_valid       <= s1_valid;
         s2_hit         <= s1_hit;
         s2_col         <= s1_col;
         pixel_on       <= s2_hit && rom_row[COL_W'(GLYPH_W - 1) - s2_col];
         pixel_on_valid <= s2_valid;
      end
   end

   glyph_rom #(
      .GLYPH_W    (GLYPH_W),
      .GLYPH_H    (GLYPH_H),
      .NUM_GLYPHS (NUM_GLYPHS),
      .CODE_W     (CODE_W),
      .ROW_W      (ROW_W)
   ) u_rom (
      .clock_25 (clock_25),
      .addr     (s1_addr),
      .row_bits (rom_row)
   );

endmodule

// File: tb/tb_glyph_text_renderer.sv
// Directed bench for glyph_text_renderer: an unscaled and a 2x-scaled instance share all inputs.
// Define GLYPH_BLINK_EN for both RTL and bench to include the blink scenario.
module tb_glyph_text_renderer;

   localparam int X0 = 240;
   localparam int Y0 = 230;
   localparam int GW = 20;
   localparam int GH = 20;

   logic       clock_25 = 1'b0;
   logic       resetn = 1'b0;
   logic       frame_start = 1'b0;
   logic [9:0] pixel_x = '0;
   logic [9:0] pixel_y = '0;
   logic       pixel_valid = 1'b0;
   logic       text_enable = 1'b1;
   logic       wr_en = 1'b0;
   logic [2:0] wr_slot = '0;
   logic [2:0] wr_code = '0;
   logic       pixel_on0, pixel_on_valid0, pixel_on1, pixel_on_valid1;

   int checks = 0;
   int failures = 0;

   always #20 clock_25 = ~clock_25;

   glyph_text_renderer #(.SCALE_LOG2(0), .BLINK_FRAMES(2)) dut (
      .clock_25(clock_25), .resetn(resetn), .frame_start(frame_start),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
      .text_enable(text_enable), .wr_en(wr_en), .wr_slot(wr_slot), .wr_code(wr_code),
      .pixel_on(pixel_on0), .pixel_on_valid(pixel_on_valid0));

   glyph_text_renderer #(.SCALE_LOG2(1), .BLINK_FRAMES(2)) dut_s (
      .clock_25(clock_25), .resetn(resetn), .frame_start(frame_start),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
      .text_enable(text_enable), .wr_en(wr_en), .wr_slot(wr_slot), .wr_code(wr_code),
      .pixel_on(pixel_on1), .pixel_on_valid(pixel_on_valid1));

   // ---------------- driver tasks ----------------
   task automatic do_write(input int slot, input int code);
      @(negedge clock_25);
      wr_en = 1'b1; wr_slot = 3'(slot); wr_code = 3'(code);
      @(negedge clock_25);
      wr_en = 1'b0;
   endtask

   task automatic pulse_frame();
      @(negedge clock_25);
      frame_start = 1'b1;
      @(negedge clock_25);
      frame_start = 1'b0;
   endtask

   task automatic write_new_game();
      for (int i = 0; i < 8; i++) do_write(i, i);
   endtask

   // One pixel in, result sampled three clock edges later; early_v is the valid after two edges.
   task automatic probe(input int x, input int y, input logic v,
                        output logic on0, output logic on1, output logic ov0, output logic early_v);
      @(negedge clock_25);
      pixel_x = 10'(x); pixel_y = 10'(y); pixel_valid = v;
      @(negedge clock_25);
      pixel_valid = 1'b0;
      @(negedge clock_25);
      early_v = pixel_on_valid0;
      @(negedge clock_25);
      on0 = pixel_on0; on1 = pixel_on1; ov0 = pixel_on_valid0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic seen;
      resetn = 1'b0;
      repeat (2) @(negedge clock_25);
      checks++;
      if (pixel_on0 !== 1'b0 || pixel_on_valid0 !== 1'b0) begin
         failures++;
         $display("FAIL reset_out got on=%0b v=%0b exp on=0 v=0", pixel_on0, pixel_on_valid0);
      end
      resetn = 1'b1;
      seen = 1'b0;
      for (int y = Y0 - 1; y <= Y0 + 2 * GH; y++) begin
         for (int x = X0 - 2; x <= X0 + 330; x++) begin
            @(negedge clock_25);
            if (pixel_on0 === 1'b1 || pixel_on1 === 1'b1) seen = 1'b1;
            pixel_x = 10'(x); pixel_y = 10'(y); pixel_valid = 1'b1;
         end
      end
      @(negedge clock_25);
      pixel_valid = 1'b0;
      repeat (3) begin
         @(negedge clock_25);
         if (pixel_on0 === 1'b1 || pixel_on1 === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL reset_scan got lit=%0b exp lit=0", seen);
      end
   endtask

   task automatic test_new_game();
      logic on0, on1, ov0, ev;
      // stimulus table: x, y, expected pixel_on of the unscaled instance
      int tx [8] = '{X0,   X0 + 1, X0 + 3 * GW, X0 + 5, X0 + 19, X0 + 30, X0 + 20, X0 + 104};
      int ty [8] = '{Y0,   Y0 + 1, Y0,          Y0,     Y0,      Y0 + 5,  Y0 + 5,  Y0};
      logic te [8] = '{1'b1, 1'b1, 1'b0,         1'b0,   1'b1,    1'b0,    1'b1,    1'b1};
      write_new_game();
      pulse_frame();
      probe(X0, Y0, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (ev !== 1'b0 || ov0 !== 1'b1) begin
         failures++;
         $display("FAIL latency got v@2=%0b v@3=%0b exp v@2=0 v@3=1", ev, ov0);
      end
      for (int i = 0; i < 8; i++) begin
         probe(tx[i], ty[i], 1'b1, on0, on1, ov0, ev);
         checks++;
         if (on0 !== te[i]) begin
            failures++;
            $display("FAIL ng_pix%0d (%0d,%0d) got=%0b exp=%0b", i, tx[i], ty[i], on0, te[i]);
         end
      end
      probe(X0 + 159, Y0 + 19, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on0 !== 1'b1) begin
         failures++;
         $display("FAIL ng_last_corner got=%0b exp=1", on0);
      end
      // 2x instance: glyph pixel (0,0) covers a 2x2 block; region ends at X0+319
      probe(X0 + 1, Y0 + 1, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on1 !== 1'b1) begin failures++; $display("FAIL s2_11 got=%0b exp=1", on1); end
      probe(X0, Y0 + 1, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on1 !== 1'b1) begin failures++; $display("FAIL s2_01 got=%0b exp=1", on1); end
      probe(X0 + 319, Y0, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on1 !== 1'b1) begin failures++; $display("FAIL s2_end_in got=%0b exp=1", on1); end
      probe(X0 + 320, Y0, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on1 !== 1'b0) begin failures++; $display("FAIL s2_end_out got=%0b exp=0", on1); end
      probe(X0 + 10, Y0, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on1 !== 1'b0) begin failures++; $display("FAIL s2_gap got=%0b exp=0", on1); end
   endtask

   task automatic test_back_to_back();
      int   bx [6] = '{X0,   X0 + 5, X0 + 19, X0 + 19, X0 + 20, X0 - 1};
      logic bv [6] = '{1'b1, 1'b1,   1'b1,    1'b0,    1'b1,    1'b1};
      logic be [6] = '{1'b1, 1'b0,   1'b1,    1'b0,    1'b1,    1'b0};
      for (int i = 0; i < 9; i++) begin
         @(negedge clock_25);
         if (i >= 3) begin
            checks++;
            if (pixel_on0 !== be[i-3] || pixel_on_valid0 !== bv[i-3]) begin
               failures++;
               $display("FAIL b2b_%0d got on=%0b v=%0b exp on=%0b v=%0b",
                        i - 3, pixel_on0, pixel_on_valid0, be[i-3], bv[i-3]);
            end
         end
         if (i < 6) begin
            pixel_x = 10'(bx[i]); pixel_y = 10'(Y0); pixel_valid = bv[i];
         end else begin
            pixel_valid = 1'b0;
         end
      end
   endtask

   task automatic test_shadow();
      logic on0, on1, ov0, ev;
      do_write(0, 3);
      probe(X0, Y0, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on0 !== 1'b1) begin failures++; $display("FAIL shadow_hidden got=%0b exp=1", on0); end
      pulse_frame();
      probe(X0, Y0, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on0 !== 1'b0) begin failures++; $display("FAIL shadow_commit got=%0b exp=0", on0); end
      @(negedge clock_25);
      frame_start = 1'b1; wr_en = 1'b1; wr_slot = 3'd0; wr_code = 3'd0;
      @(negedge clock_25);
      frame_start = 1'b0; wr_en = 1'b0;
      probe(X0, Y0, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on0 !== 1'b0) begin failures++; $display("FAIL coincident_excluded got=%0b exp=0", on0); end
      pulse_frame();
      probe(X0, Y0, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on0 !== 1'b1) begin failures++; $display("FAIL coincident_next got=%0b exp=1", on0); end
   endtask

   task automatic test_out_of_range();
      logic on0, on1, ov0, ev;
      probe(X0 - 1, Y0, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on0 !== 1'b0 || ov0 !== 1'b1) begin
         failures++; $display("FAIL left_edge got on=%0b v=%0b exp on=0 v=1", on0, ov0);
      end
      probe(X0, Y0 + GH, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on0 !== 1'b0 || ov0 !== 1'b1) begin
         failures++; $display("FAIL bottom_edge got on=%0b v=%0b exp on=0 v=1", on0, ov0);
      end
      probe(X0, Y0, 1'b0, on0, on1, ov0, ev);
      checks++;
      if (on0 !== 1'b0 || on1 !== 1'b0 || ov0 !== 1'b0) begin
         failures++; $display("FAIL not_valid got on=%0b/%0b v=%0b exp on=0/0 v=0", on0, on1, ov0);
      end
   endtask

   task automatic test_text_enable();
      logic on0, on1, ov0, ev;
      text_enable = 1'b0;
      probe(X0 + 1, Y0 + 1, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on0 !== 1'b0 || on1 !== 1'b0 || ov0 !== 1'b1) begin
         failures++; $display("FAIL text_off got on=%0b/%0b v=%0b exp on=0/0 v=1", on0, on1, ov0);
      end
      text_enable = 1'b1;
      probe(X0 + 1, Y0 + 1, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on0 !== 1'b1 || on1 !== 1'b1) begin
         failures++; $display("FAIL text_on got on=%0b/%0b exp on=1/1", on0, on1);
      end
   endtask

`ifdef GLYPH_BLINK_EN
   task automatic test_blink();
      logic on0, on1, ov0, ev;
      logic exp_lit [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      @(negedge clock_25);
      resetn = 1'b0;
      repeat (2) @(negedge clock_25);
      resetn = 1'b1;
      write_new_game();
      for (int f = 1; f <= 5; f++) begin
         pulse_frame();
         probe(X0, Y0, 1'b1, on0, on1, ov0, ev);
         checks++;
         if (on0 !== exp_lit[f]) begin
            failures++; $display("FAIL blink_frame%0d got=%0b exp=%0b", f, on0, exp_lit[f]);
         end
      end
   endtask
`endif

   task automatic test_reset_mid();
      logic on0, on1, ov0, ev;
      @(negedge clock_25);
      pixel_x = 10'(X0); pixel_y = 10'(Y0); pixel_valid = 1'b1;
      repeat (4) @(negedge clock_25);
      checks++;
      if (pixel_on0 !== 1'b1) begin failures++; $display("FAIL pre_reset_lit got=%0b exp=1", pixel_on0); end
      resetn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock_25);
         checks++;
         if (pixel_on0 !== 1'b0 || pixel_on_valid0 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset%0d got on=%0b v=%0b exp on=0 v=0", i, pixel_on0, pixel_on_valid0);
         end
      end
      resetn = 1'b1;
      pixel_valid = 1'b0;
      probe(X0, Y0, 1'b1, on0, on1, ov0, ev);
      checks++;
      if (on0 !== 1'b0 || ov0 !== 1'b1) begin
         failures++; $display("FAIL post_reset_blank got on=%0b v=%0b exp on=0 v=1", on0, ov0);
      end
   endtask

   initial begin
      test_reset();
      test_new_game();
      test_back_to_back();
      test_shadow();
      test_out_of_range();
      test_text_enable();
`ifdef GLYPH_BLINK_EN
      test_blink();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
